// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - word-addressed data RAM with posted-write buffer, forwarding and sticky bus error; optional access counters under DATA_RAM_ACCESS_COUNT_EN
module data_ram_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h00001000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        bus_error,
`ifdef DATA_RAM_ACCESS_COUNT_EN
  output logic [31:0] bus_error_addr,
  output logic [31:0] read_count,
  output logic [31:0] write_count
`else
  output logic [31:0] bus_error_addr
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];

  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  capture;
  logic                  err_now;

  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_idx;
  logic [31:0]           buf_data;
  logic [3:0]            buf_be;

  logic [31:0]           arr_word;
  logic [31:0]           merged;
  logic                  fwd_hit;

  // Byte offset bits carry no meaning for a word-wide array.
  logic                  unused_byte_offset;
  assign unused_byte_offset = ^data_address[1:0];

  assign in_range = (data_address[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign idx      = data_address[ADDR_WIDTH+1:2];
  assign capture  = data_write && in_range;
  assign err_now  = ((data_read || data_write) && !in_range) || (data_read && data_write);

  // Zero-latency load path: array word with buffered lanes overlaid on an index hit.
  always_comb begin
    arr_word = mem[idx];
    fwd_hit  = buf_valid && (buf_idx == idx);
    merged   = arr_word;
    for (int i = 0; i < 4; i++) begin
      if (fwd_hit && buf_be[i]) begin
        merged[8*i +: 8] = buf_data[8*i +: 8];
      end
    end
    data_readdata = (data_read && in_range) ? merged : 32'h0;
  end

  // Posted-write buffer: a new capture replaces the entry being committed on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= 32'h0;
      buf_be    <= 4'h0;
    end else if (clk_enable) begin
      if (capture) begin
        buf_valid <= 1'b1;
        buf_idx   <= idx;
        buf_data  <= data_writedata;
        buf_be    <= data_byteenable;
      end else begin
        buf_valid <= 1'b0;
      end
    end
  end

  // Commit the buffered bytes; contents survive reset and buf_valid already gates a discarded entry.
  always_ff @(posedge clk) begin
    if (clk_enable && buf_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_be[i]) begin
          mem[buf_idx][8*i +: 8] <= buf_data[8*i +: 8];
        end
      end
    end
  end

  // Sticky error flag; the address is latched only on the edge that first sets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_error      <= 1'b0;
      bus_error_addr <= 32'h0;
    end else if (clk_enable && err_now && !bus_error) begin
      bus_error      <= 1'b1;
      bus_error_addr <= data_address;
    end
  end

`ifdef DATA_RAM_ACCESS_COUNT_EN
  // Free-running access counters for in-range strobes; wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_count  <= 32'h0;
      write_count <= 32'h0;
    end else if (clk_enable) begin
      if (data_read && in_range) begin
        read_count <= read_count + 32'd1;
      end
      if (data_write && in_range) begin
        write_count <= write_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - scoreboard bench for data_ram_responder
module tb_data_ram_responder;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        bus_error;
  logic [31:0] bus_error_addr;
`ifdef DATA_RAM_ACCESS_COUNT_EN
  logic [31:0] read_count;
  logic [31:0] write_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];

  data_ram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .data_address    (data_address),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_byteenable (data_byteenable),
    .data_writedata  (data_writedata),
    .data_readdata   (data_readdata),
    .bus_error       (bus_error),
`ifdef DATA_RAM_ACCESS_COUNT_EN
    .bus_error_addr  (bus_error_addr),
    .read_count      (read_count),
    .write_count     (write_count)
`else
    .bus_error_addr  (bus_error_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_read  = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    data_address    = addr;
    data_writedata  = data;
    data_byteenable = be;
    data_write      = 1'b1;
    data_read       = 1'b0;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] e;
    data_address = addr;
    data_read    = 1'b1;
    data_write   = 1'b0;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (data_readdata !== e) begin
      failures++;
      $display("FAIL %s: readdata got %h expected %h", name, data_readdata, e);
    end
    step();
    idle();
  endtask

  task automatic chk_err(input logic exp_err, input logic [31:0] exp_addr, input string name);
    checks++;
    if (bus_error !== exp_err) begin
      failures++;
      $display("FAIL %s: bus_error got %b expected %b", name, bus_error, exp_err);
    end
    checks++;
    if (bus_error_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s: bus_error_addr got %h expected %h", name, bus_error_addr, exp_addr);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle();
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    chk_err(1'b0, 32'h0, "reset_err");
    checks++;
    if (data_readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_readdata: got %h expected %h", data_readdata, 32'h0);
    end
`ifdef DATA_RAM_ACCESS_COUNT_EN
    checks++;
    if (read_count !== 32'h0 || write_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_counts: got %h/%h expected 0/0", read_count, write_count);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_forward();
    wr(32'h00001004, 32'hDEADBEEF, 4'hF);
    rd(32'h00001004, 32'hDEADBEEF, "fwd_next_cycle");
    step();
    rd(32'h00001004, 32'hDEADBEEF, "fwd_from_array");
    chk_err(1'b0, 32'h0, "fwd_no_err");
  endtask

  task automatic test_partial();
    wr(32'h00001008, 32'h11223344, 4'hF);
    step();
    wr(32'h00001008, 32'hAABBCCDD, 4'b0101);
    rd(32'h00001008, 32'h11BB33DD, "partial_fwd");
    rd(32'h00001008, 32'h11BB33DD, "partial_array");
  endtask

  task automatic test_back_to_back();
    wr(32'h00001000, 32'd1, 4'hF);
    wr(32'h00001004, 32'd2, 4'hF);
    wr(32'h00001008, 32'd3, 4'hF);
    rd(32'h00001000, 32'd1, "b2b_0");
    rd(32'h00001004, 32'd2, "b2b_1");
    rd(32'h00001008, 32'd3, "b2b_2");
  endtask

  task automatic test_be_zero();
    wr(32'h00001004, 32'hFFFFFFFF, 4'b0000);
    rd(32'h00001004, 32'd2, "be_zero_fwd");
    rd(32'h00001004, 32'd2, "be_zero_array");
  endtask

  task automatic test_error();
    rd(32'h00002000, 32'h0, "oor_read");
    chk_err(1'b1, 32'h00002000, "oor_first");
    rd(32'h00000000, 32'h0, "oor_read2");
    chk_err(1'b1, 32'h00002000, "oor_sticky");
    wr(32'h00002000, 32'h00000099, 4'hF);
    step();
    rd(32'h00001000, 32'd1, "oor_write_dropped");
  endtask

  task automatic test_rw_both();
    data_address    = 32'h00001000;
    data_writedata  = 32'h00000055;
    data_byteenable = 4'hF;
    data_read       = 1'b1;
    data_write      = 1'b1;
    exp_q.push_back(32'd1);
    @(negedge clk);
    checks++;
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      if (data_readdata !== e) begin
        failures++;
        $display("FAIL rw_both_prewrite: got %h expected %h", data_readdata, e);
      end
    end
    step();
    idle();
    rd(32'h00001000, 32'h00000055, "rw_both_written");
    chk_err(1'b1, 32'h00002000, "rw_both_err_kept");
  endtask

  task automatic test_clk_enable();
    clk_enable = 1'b0;
    wr(32'h00001000, 32'h00000077, 4'hF);
    rd(32'h00001000, 32'h00000055, "cke_low_read");
    clk_enable = 1'b1;
    step();
    rd(32'h00001000, 32'h00000055, "cke_no_capture");
  endtask

  task automatic test_reset_discard();
    wr(32'h0000100C, 32'h0000CAFE, 4'hF);
    step();
    wr(32'h0000100C, 32'h0000BEEF, 4'hF);
    reset = 1'b0;
    #2;
    chk_err(1'b0, 32'h0, "async_reset_err");
    @(negedge clk);
    reset = 1'b1;
    step();
    rd(32'h0000100C, 32'h0000CAFE, "reset_discard");
  endtask

`ifdef DATA_RAM_ACCESS_COUNT_EN
  task automatic test_counters();
    apply_reset();
    rd(32'h00001000, 32'h00000055, "cnt_rd0");
    rd(32'h00001000, 32'h00000055, "cnt_rd1");
    rd(32'h00001000, 32'h00000055, "cnt_rd2");
    wr(32'h00001010, 32'h1, 4'hF);
    wr(32'h00001014, 32'h2, 4'hF);
    clk_enable = 1'b0;
    wr(32'h00001018, 32'h3, 4'hF);
    clk_enable = 1'b1;
    checks++;
    if (read_count !== 32'd3) begin
      failures++;
      $display("FAIL read_count: got %0d expected %0d", read_count, 3);
    end
    checks++;
    if (write_count !== 32'd2) begin
      failures++;
      $display("FAIL write_count: got %0d expected %0d", write_count, 2);
    end
  endtask
`endif

  initial begin
    reset           = 1'b0;
    clk_enable      = 1'b1;
    data_address    = 32'h0;
    data_read       = 1'b0;
    data_write      = 1'b0;
    data_byteenable = 4'h0;
    data_writedata  = 32'h0;
    test_reset();
    test_forward();
    test_partial();
    test_back_to_back();
    test_be_zero();
    test_error();
    test_rw_both();
    test_clk_enable();
    test_reset_discard();
`ifdef DATA_RAM_ACCESS_COUNT_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
